// File: rtl/ofdm_frame_scheduler_if.sv
// Sample-stream handshake between the subcarrier mux, the scheduler and the IFFT sink.
// The master side drives the mux valid/sop and the sink ready. The scheduler sits on the slave side.
interface ofdm_frame_scheduler_if;
  logic valid_in;
  logic sop_in;
  logic ready_in;
  logic ready_out;

  modport master (output valid_in, output sop_in, output ready_in, input ready_out);
  modport slave  (input valid_in, input sop_in, input ready_in, output ready_out);
endinterface

// File: rtl/ofdm_frame_scheduler.sv
// Frame sequencer for the OFDM transmit chain: gates mux ready, counts NFFT samples per
// symbol, inserts an idle gap between symbols and reports frame/symbol status.
module ofdm_frame_scheduler #(
  parameter int NFFT       = 1024,
  parameter int GAP_CYCLES = 16,
  parameter int SYM_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start,
  input  logic                 stop,
  input  logic [SYM_W-1:0]     num_symbols,
  ofdm_frame_scheduler_if.slave strm,
  output logic                 busy,
  output logic [SYM_W-1:0]     sym_idx,
  output logic                 sof,
  output logic                 eof,
  output logic                 done,
  output logic                 err_sop,
  output logic                 err_ovf
);

  localparam int CW       = $clog2(NFFT);
  localparam int GW       = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    sample_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [SYM_W-1:0] num_lat;
  logic             stop_pend;
  logic             sof_q, eof_q;

  logic start_acc, accept, sym_end, last_sym, ovf_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else if (en) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    accept    = 1'b0;
    sym_end   = 1'b0;
    last_sym  = 1'b0;
    ovf_hit   = 1'b0;
    if (en) begin
      ovf_hit = strm.valid_in && (state != RUN);
      case (state)
        IDLE: begin
          if (start && (num_symbols != '0)) begin
            start_acc = 1'b1;
            state_nxt = RUN;
          end
        end
        RUN: begin
          accept   = strm.valid_in;
          sym_end  = accept && (sample_cnt == '1);
          // A stop arriving on the final sample of a symbol still ends the frame there.
          last_sym = sym_end && ((sym_idx == num_lat - SYM_W'(1)) || stop_pend || stop);
          if (last_sym) state_nxt = DONE;
          else if (sym_end) state_nxt = (GAP_CYCLES == 0) ? RUN : GAP;
        end
        GAP: begin
          if (stop) state_nxt = DONE;
          else if (gap_cnt == '0) state_nxt = RUN;
        end
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_cnt <= '0;
      gap_cnt    <= '0;
      num_lat    <= '0;
      sym_idx    <= '0;
      stop_pend  <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      err_sop    <= 1'b0;
      err_ovf    <= 1'b0;
    end else if (en) begin
      sof_q <= accept && (sym_idx == '0) && (sample_cnt == '0);
      eof_q <= last_sym;
      if (state != GAP) gap_cnt <= GW'(GAP_LOAD);
      else if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
      if (start_acc) begin
        num_lat    <= num_symbols;
        sym_idx    <= '0;
        sample_cnt <= '0;
        stop_pend  <= 1'b0;
        err_sop    <= 1'b0;
        err_ovf    <= 1'b0;
      end else begin
        if (ovf_hit) err_ovf <= 1'b1;
        if (accept) begin
          sample_cnt <= sample_cnt + CW'(1);
          if (strm.sop_in != (sample_cnt == '0)) err_sop <= 1'b1;
        end
        if (sym_end && !last_sym) sym_idx <= sym_idx + SYM_W'(1);
        if (state == DONE) stop_pend <= 1'b0;
        else if (stop && ((state == RUN) || (state == GAP))) stop_pend <= 1'b1;
      end
    end else begin
      sof_q <= 1'b0;
      eof_q <= 1'b0;
    end
  end

  assign strm.ready_out = en && (state == RUN) && strm.ready_in;
  assign busy           = (state != IDLE);
  assign done           = en && (state == DONE);
  assign sof            = en && sof_q;
  assign eof            = en && eof_q;

endmodule

// File: tb/tb_ofdm_frame_scheduler.sv
// Directed bench for ofdm_frame_scheduler: NFFT=8, GAP_CYCLES=3, mux model offers a sample
// whenever ready_out is high, with sop on each symbol's first sample.
module tb_ofdm_frame_scheduler;
  localparam int NFFT = 8;
  localparam int GAP  = 3;
  localparam int SW   = 8;

  logic          clk = 1'b0;
  logic          rst, en, start, stop;
  logic [SW-1:0] num_symbols;
  logic          busy, sof, eof, done, err_sop, err_ovf;
  logic [SW-1:0] sym_idx;

  ofdm_frame_scheduler_if strm();

  ofdm_frame_scheduler #(.NFFT(NFFT), .GAP_CYCLES(GAP), .SYM_W(SW)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .num_symbols(num_symbols),
    .strm(strm), .busy(busy), .sym_idx(sym_idx), .sof(sof), .eof(eof), .done(done),
    .err_sop(err_sop), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int n_acc, n_sof, sof_acc, n_eof, n_both, n_done, low_cnt, done_iter, gapd, lastacc;
  bit timed_out;
  int acc_cyc[$];
  int syms[$];

  task automatic do_start(input logic [SW-1:0] n);
    num_symbols = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Mux/sink model: runs until done, until `limit` samples have been accepted, or until budget expires.
  task automatic run_frame(input int budget, input bit toggle, input int stop_at, input int bad_sop_at,
                           input bit inject_gap, input int acc0, input int limit);
    bit stop_sent = 1'b0;
    bit injected = 1'b0;
    n_acc = acc0; n_sof = 0; sof_acc = -1; n_eof = 0; n_both = 0; n_done = 0;
    low_cnt = 0; done_iter = -1; timed_out = 1'b1;
    acc_cyc.delete(); syms.delete();
    for (int c = 0; c < budget; c++) begin
      strm.ready_in = toggle ? (c % 2 == 0) : 1'b1;
      #1;
      strm.valid_in = strm.ready_out;
      strm.sop_in   = strm.ready_out && (((n_acc % NFFT) == 0) || (n_acc == bad_sop_at));
      if (busy && !strm.ready_out) begin
        low_cnt++;
        if (inject_gap && !injected) begin
          strm.valid_in = 1'b1;
          injected = 1'b1;
        end
      end
      stop = (n_acc == stop_at) && !stop_sent && strm.ready_out;
      if (stop) stop_sent = 1'b1;
      if (strm.ready_out) begin
        acc_cyc.push_back(c);
        syms.push_back(int'(sym_idx));
        n_acc++;
      end
      @(posedge clk); #1;
      stop = 1'b0;
      if (sof) begin n_sof++; sof_acc = n_acc; end
      if (eof) n_eof++;
      if (eof && done) n_both++;
      if (done) begin n_done++; done_iter = c; timed_out = 1'b0; break; end
      if (n_acc == limit) begin timed_out = 1'b0; break; end
    end
    strm.valid_in = 1'b0;
    strm.sop_in = 1'b0;
    stop = 1'b0;
    gapd = (acc_cyc.size() > 8) ? acc_cyc[8] - acc_cyc[7] : -1;
    lastacc = (acc_cyc.size() > 0) ? acc_cyc[acc_cyc.size()-1] : -2;
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b1; start = 1'b0; stop = 1'b0; num_symbols = '0;
    strm.ready_in = 1'b1; strm.valid_in = 1'b0; strm.sop_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (strm.ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", strm.ready_out); end
    checks++; if (sym_idx !== 8'd0) begin errors++; $display("FAIL reset_sym_idx: got %0d want 0", sym_idx); end
    checks++; if ({sof, eof, done} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b want 000", {sof, eof, done}); end
    checks++; if ({err_sop, err_ovf} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b want 00", {err_sop, err_ovf}); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_frame;
    do_start(8'd2);
    run_frame(200, 1'b0, -1, -1, 1'b0, 0, -1);
    checks++; if (timed_out) begin errors++; $display("FAIL t1_timeout: got no done want done"); end
    checks++; if (n_acc !== 16) begin errors++; $display("FAIL t1_samples: got %0d want 16", n_acc); end
    checks++; if (low_cnt !== GAP) begin errors++; $display("FAIL t1_ready_low: got %0d want %0d", low_cnt, GAP); end
    checks++; if (gapd !== GAP + 1) begin errors++; $display("FAIL t1_gap_dist: got %0d want %0d", gapd, GAP + 1); end
    checks++; if (n_sof !== 1 || sof_acc !== 1) begin errors++; $display("FAIL t1_sof: got count %0d at %0d want 1 at 1", n_sof, sof_acc); end
    checks++; if (n_eof !== 1 || n_both !== 1) begin errors++; $display("FAIL t1_eof_done: got eof %0d both %0d want 1 1", n_eof, n_both); end
    checks++; if (done_iter !== lastacc) begin errors++; $display("FAIL t1_done_lat: got %0d want %0d", done_iter, lastacc); end
    checks++; if (syms.size() !== 16 || syms[0] !== 0 || syms[7] !== 0 || syms[8] !== 1 || syms[15] !== 1) begin
      errors++; $display("FAIL t1_sym_idx: got size %0d want 0..0,1..1", syms.size()); end
    checks++; if (strm.ready_out !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL t1_done_state: got ready %b busy %b want 0 1", strm.ready_out, busy); end
    checks++; if ({err_sop, err_ovf} !== 2'b00) begin errors++; $display("FAIL t1_errs: got %b want 00", {err_sop, err_ovf}); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || sym_idx !== 8'd1) begin errors++; $display("FAIL t1_idle: got busy %b idx %0d want 0 1", busy, sym_idx); end
  endtask

  task automatic test_ready_toggle;
    do_start(8'd2);
    run_frame(300, 1'b1, -1, -1, 1'b0, 0, -1);
    checks++; if (timed_out) begin errors++; $display("FAIL t2_timeout: got no done want done"); end
    checks++; if (n_acc !== 16) begin errors++; $display("FAIL t2_samples: got %0d want 16", n_acc); end
    checks++; if (gapd !== GAP + 1) begin errors++; $display("FAIL t2_gap_dist: got %0d want %0d", gapd, GAP + 1); end
    checks++; if (n_both !== 1) begin errors++; $display("FAIL t2_eof_done: got %0d want 1", n_both); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t2_single_done: got done %b busy %b want 0 0", done, busy); end
  endtask

  task automatic test_stop;
    do_start(8'd4);
    run_frame(300, 1'b0, 11, -1, 1'b0, 0, -1);
    checks++; if (timed_out) begin errors++; $display("FAIL t3_timeout: got no done want done"); end
    checks++; if (n_acc !== 16) begin errors++; $display("FAIL t3_samples: got %0d want 16", n_acc); end
    checks++; if (sym_idx !== 8'd1) begin errors++; $display("FAIL t3_sym_idx: got %0d want 1", sym_idx); end
    checks++; if (n_eof !== 1 || n_both !== 1) begin errors++; $display("FAIL t3_eof: got eof %0d both %0d want 1 1", n_eof, n_both); end
    @(posedge clk); #1;
    do_start(8'd4);
    run_frame(100, 1'b0, -1, -1, 1'b0, 0, 8);
    checks++; if (timed_out) begin errors++; $display("FAIL t3b_timeout: got no gap want gap"); end
    checks++; if (strm.ready_out !== 1'b0 || busy !== 1'b1 || sym_idx !== 8'd1) begin
      errors++; $display("FAIL t3b_in_gap: got ready %b busy %b idx %0d want 0 1 1", strm.ready_out, busy, sym_idx); end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t3b_done: got %b want 1", done); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || strm.ready_out !== 1'b0) begin errors++; $display("FAIL t3b_idle: got busy %b ready %b want 0 0", busy, strm.ready_out); end
  endtask

  task automatic test_sop_error;
    do_start(8'd2);
    run_frame(100, 1'b0, -1, 5, 1'b0, 0, 6);
    checks++; if (err_sop !== 1'b1) begin errors++; $display("FAIL t4_err_set: got %b want 1", err_sop); end
    run_frame(100, 1'b0, -1, -1, 1'b0, 6, -1);
    checks++; if (timed_out || n_acc !== 16) begin errors++; $display("FAIL t4_samples: got %0d want 16", n_acc); end
    checks++; if (err_sop !== 1'b1) begin errors++; $display("FAIL t4_err_sticky: got %b want 1", err_sop); end
    @(posedge clk); #1;
    do_start(8'd1);
    checks++; if (err_sop !== 1'b0) begin errors++; $display("FAIL t4_err_clear: got %b want 0", err_sop); end
    run_frame(100, 1'b0, -1, -1, 1'b0, 0, -1);
    checks++; if (err_sop !== 1'b0 || n_acc !== 8) begin errors++; $display("FAIL t4_clean: got err %b n %0d want 0 8", err_sop, n_acc); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow;
    strm.valid_in = 1'b1;
    @(posedge clk); #1;
    strm.valid_in = 1'b0;
    checks++; if (err_ovf !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL t5_idle_ovf: got ovf %b busy %b want 1 0", err_ovf, busy); end
    do_start(8'd2);
    checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL t5_ovf_clear: got %b want 0", err_ovf); end
    run_frame(200, 1'b0, -1, -1, 1'b1, 0, -1);
    checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL t5_gap_ovf: got %b want 1", err_ovf); end
    checks++; if (timed_out || n_acc !== 16 || gapd !== GAP + 1) begin errors++; $display("FAIL t5_counts: got n %0d gap %0d want 16 %0d", n_acc, gapd, GAP + 1); end
    checks++; if (err_sop !== 1'b0) begin errors++; $display("FAIL t5_sop: got %b want 0", err_sop); end
    @(posedge clk); #1;
    do_start(8'd0);
    checks++; if (busy !== 1'b0 || strm.ready_out !== 1'b0 || sym_idx !== 8'd1) begin
      errors++; $display("FAIL t5_zero_start: got busy %b ready %b idx %0d want 0 0 1", busy, strm.ready_out, sym_idx); end
  endtask

  task automatic test_reset_and_enable;
    int extra_done = 0;
    do_start(8'd2);
    run_frame(100, 1'b0, -1, -1, 1'b0, 0, 10);
    #2 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || strm.ready_out !== 1'b0 || sym_idx !== 8'd0 || done !== 1'b0) begin
      errors++; $display("FAIL t6_async_rst: got busy %b ready %b idx %0d done %b want 0 0 0 0", busy, strm.ready_out, sym_idx, done); end
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done || busy) extra_done++;
    end
    checks++; if (extra_done !== 0) begin errors++; $display("FAIL t6_no_done: got %0d active cycles want 0", extra_done); end
    do_start(8'd1);
    run_frame(100, 1'b0, -1, -1, 1'b0, 0, 3);
    en = 1'b0;
    strm.valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (strm.ready_out !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL t6_en_freeze: got ready %b busy %b done %b want 0 1 0", strm.ready_out, busy, done); end
    end
    strm.valid_in = 1'b0;
    en = 1'b1;
    run_frame(100, 1'b0, -1, -1, 1'b0, 3, -1);
    checks++; if (timed_out || n_acc !== 8 || n_both !== 1) begin errors++; $display("FAIL t6_resume: got n %0d both %0d want 8 1", n_acc, n_both); end
    checks++; if ({err_sop, err_ovf} !== 2'b00) begin errors++; $display("FAIL t6_errs: got %b want 00", {err_sop, err_ovf}); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_ready_toggle();
    test_stop();
    test_sop_error();
    test_overflow();
    test_reset_and_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ofdm_frame_scheduler.md
Name: ofdm_frame_scheduler

Overview:
- Sequences the OFDM transmit chain (ROM counter -> QAM -> pilot/subcarrier mux) into frames of a programmable number of OFDM symbols.
- Gates the mux's ready, counts NFFT accepted samples per symbol, and inserts a fixed idle gap between symbols so the downstream IFFT can unload.
- Checks sop alignment, reports frame start/end/done and symbol index.

Parameters:
NFFT, 1024, samples (subcarriers) per OFDM symbol; power of two, >=4
GAP_CYCLES, 16, idle cycles between symbols of one frame; 0 allowed
SYM_W, 8, width of symbol count/index

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
en  in  1  global enable; low freezes all state
start  in  1  one-cycle frame request
stop  in  1  one-cycle request: finish current symbol, then end frame
num_symbols  in  SYM_W  symbols per frame, sampled on accepted start
ready_in  in  1  downstream (IFFT/sink) ready
valid_in  in  1  valid from subcarrier mux
sop_in  in  1  sop from subcarrier mux
ready_out  out  1  ready to subcarrier mux
busy  out  1  frame in progress
sym_idx  out  SYM_W  index of current symbol, 0-based
sof  out  1  pulse: first sample of frame accepted
eof  out  1  pulse: last sample of frame accepted
done  out  1  pulse: frame complete
err_sop  out  1  sticky: sop misaligned or missing
err_ovf  out  1  sticky: valid_in seen while not in RUN

Behaviour:
- Reset (rst=0, async): state IDLE; all counters, registered outputs and sticky errors 0; ready_out=0.
- en=0: no state, counter or flag changes; ready_out=0; pulses (sof/eof/done) are 0.
- States: IDLE, RUN, GAP, DONE.
  - IDLE: start=1 with num_symbols!=0 latches num_symbols, clears err_sop/err_ovf, sym_idx=0, sample_cnt=0 -> RUN. start with num_symbols=0 is ignored. start while not IDLE is ignored.
  - RUN: ready_out = ready_in (combinational from state). Accepted sample = valid_in=1 in RUN with en=1. Each accepted sample increments sample_cnt (log2(NFFT) bits, wraps to 0 after NFFT-1).
  - End of symbol: accepted sample with sample_cnt=NFFT-1.
    - Goes to DONE if sym_idx=latched-1 or a stop is pending.
    - Otherwise sym_idx+1 and goes to GAP, or straight to RUN when GAP_CYCLES=0.
    - ready_out drops the cycle after the last sample is accepted.
  - GAP: ready_out=0; down-counter loaded with GAP_CYCLES-1, -> RUN when it reaches 0, i.e. exactly GAP_CYCLES idle cycles.
  - DONE: one cycle, done=1, busy=0 next cycle -> IDLE.
- busy=1 in RUN, GAP and DONE.
- stop: sets a pending flag in RUN or GAP; ignored in IDLE/DONE. A symbol is never truncated.
  - stop in GAP -> DONE next cycle without starting a new symbol.
  - stop and start in the same cycle in IDLE: start wins, stop ignored.
- sof: registered, 1 the cycle after the accepted sample with sym_idx=0, sample_cnt=0.
- eof: registered, 1 the cycle after the frame's final accepted sample; coincides with the DONE cycle (done=eof that cycle).
- err_sop set on accepted sample when sop_in != (sample_cnt==0). Counting continues; there is no resync.
- err_ovf set when valid_in=1 outside RUN. The sample is not counted.
- sym_idx is stable through GAP and holds its last value in DONE/IDLE until the next start.
- rst mid-frame: immediate IDLE; no done/eof emitted.

Test Plan:
1. NFFT=8, GAP_CYCLES=3, num_symbols=2, ready_in=1, mux valid every RUN cycle with sop on each symbol's first sample -> 8 samples, ready_out low exactly 3 cycles, 8 samples; sof once, eof and done together one cycle after sample 16; sym_idx 0 then 1; no errors.
2. Same config, ready_in toggled 1/0 every cycle -> still exactly 16 accepted samples, done once, gap still 3 cycles.
3. num_symbols=4, stop pulsed at sample 3 of symbol 1 -> symbol 1 completes (8 samples), done after 16 samples, sym_idx ends 1; stop during GAP of a new frame -> done on next cycle, no further ready.
4. sop_in asserted on sample 5 of symbol 0 -> err_sop=1 and stays set through the frame; cleared by the next accepted start.
5. valid_in=1 in IDLE and during GAP -> err_ovf=1; sample counts unchanged (frame still 8 samples/symbol); start with num_symbols=0 -> stays IDLE, busy=0.
6. rst=0 asserted mid-RUN (async, between edges) -> outputs 0 immediately, no done; en=0 held 5 cycles in RUN -> ready_out=0, counters frozen, frame resumes correctly after.
